uart_cmd_parser: RTL and testbench

- Sits between the UART receive/transmit byte engine and the Wishbone master request port inside the host block.
- Consumes ASCII command bytes from the UART RX path and parses "wm <addr> <data>" and "rm <addr>" lines.
- Issues one 32-bit register request per line and streams an ASCII response back to the UART TX path.

---
 rtl/uart_cmd_parser_if.sv | 30 +++
 rtl/uart_cmd_parser.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_parser_if.sv
// Handshake bundle between the command parser, the UART byte engine and the
// register request port. The master side is the parser itself.
interface uart_cmd_parser_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        reg_req;
    logic        reg_we;
    logic [31:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic        reg_ack;
    logic [31:0] reg_rdata;
    logic        busy;

    modport master (
        input  rx_valid, rx_data, tx_ready, reg_ack, reg_rdata,
        output rx_ready, tx_valid, tx_data, reg_req, reg_we, reg_addr,
               reg_wdata, reg_be, busy
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, reg_ack, reg_rdata,
        input  rx_ready, tx_valid, tx_data, reg_req, reg_we, reg_addr,
               reg_wdata, reg_be, busy
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// ASCII "wm <addr> <data>" / "rm <addr>" line parser that issues one register
// request per line and streams an OK / RD:xxxxxxxx / ERR / TO response.
module uart_cmd_parser #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int MAX_HEX     = 8
) (
    input  logic              app_clk,
    input  logic              app_rst,
    uart_cmd_parser_if.master bus
);
    localparam int CNT_W = $clog2(MAX_HEX + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_SP = 8'h20;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD_W, S_CMD_R, S_SP1, S_ADDR, S_SP2, S_DATA, S_SKIP, S_REQ, S_RESP
    } state_t;
    typedef enum logic [1:0] {R_OK, R_RD, R_ERR, R_TO} resp_t;

    state_t             state_reg, state_next;
    resp_t              resp_reg, resp_next;
    logic               is_write_reg, is_write_next;
    logic [31:0]        addr_reg, addr_next;
    logic [31:0]        wdata_reg, wdata_next;
    logic [31:0]        rdata_reg, rdata_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
    logic [3:0]         idx_reg, idx_next;
    logic               req_reg, req_next;
    logic               rx_ready_reg, rx_ready_next;

    logic               rx_fire;
    logic               is_hex;
    logic [3:0]         nibble;
    logic               bad;
    logic [3:0]         resp_last;
    logic [3:0]         idx_off;
    logic [7:0]         tx_char;
    logic [7:0]         hex_msb [8];

    assign rx_fire = bus.rx_valid & rx_ready_reg;

    always_comb begin
        is_hex = 1'b1;
        nibble = 4'h0;
        if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
            nibble = bus.rx_data[3:0];
        end else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
                     (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66)) begin
            nibble = bus.rx_data[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
        end
    end

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            state_reg    <= S_IDLE;
            resp_reg     <= R_OK;
            is_write_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            cnt_reg      <= '0;
            to_cnt_reg   <= '0;
            idx_reg      <= '0;
            req_reg      <= 1'b0;
            rx_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            resp_reg     <= resp_next;
            is_write_reg <= is_write_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            rdata_reg    <= rdata_next;
            cnt_reg      <= cnt_next;
            to_cnt_reg   <= to_cnt_next;
            idx_reg      <= idx_next;
            req_reg      <= req_next;
            rx_ready_reg <= rx_ready_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        resp_next     = resp_reg;
        is_write_next = is_write_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        rdata_next    = rdata_reg;
        cnt_next      = cnt_reg;
        to_cnt_next   = to_cnt_reg;
        idx_next      = idx_reg;
        req_next      = req_reg;
        bad           = 1'b0;

        if (rx_fire && bus.rx_data != CH_CR) begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.rx_data == 8'h77 || bus.rx_data == 8'h72) begin
                        state_next    = (bus.rx_data == 8'h77) ? S_CMD_W : S_CMD_R;
                        is_write_next = (bus.rx_data == 8'h77);
                        addr_next     = '0;
                        wdata_next    = '0;
                        cnt_next      = '0;
                    end else if (bus.rx_data != CH_SP && bus.rx_data != CH_LF) begin
                        bad = 1'b1;
                    end
                end
                S_CMD_W, S_CMD_R: begin
                    if (bus.rx_data == 8'h6D) state_next = S_SP1;
                    else                      bad = 1'b1;
                end
                S_SP1: begin
                    if (bus.rx_data == CH_SP) state_next = S_ADDR;
                    else                      bad = 1'b1;
                end
                S_ADDR: begin
                    if (is_hex && cnt_reg != CNT_W'(MAX_HEX)) begin
                        addr_next = {addr_reg[27:0], nibble};
                        cnt_next  = cnt_reg + 1'b1;
                    end else if (bus.rx_data == CH_SP && cnt_reg != '0 && is_write_reg) begin
                        state_next = S_SP2;
                        cnt_next   = '0;
                    end else if (bus.rx_data == CH_LF && cnt_reg != '0 && !is_write_reg) begin
                        state_next  = S_REQ;
                        req_next    = 1'b1;
                        to_cnt_next = '0;
                    end else begin
                        bad = 1'b1;
                    end
                end
                S_SP2, S_DATA: begin
                    if (is_hex && cnt_reg != CNT_W'(MAX_HEX)) begin
                        wdata_next = {wdata_reg[27:0], nibble};
                        cnt_next   = cnt_reg + 1'b1;
                        state_next = S_DATA;
                    end else if (bus.rx_data == CH_LF && cnt_reg != '0) begin
                        state_next  = S_REQ;
                        req_next    = 1'b1;
                        to_cnt_next = '0;
                    end else begin
                        bad = 1'b1;
                    end
                end
                S_SKIP: begin
                    if (bus.rx_data == CH_LF) begin
                        state_next = S_RESP;
                        resp_next  = R_ERR;
                        idx_next   = '0;
                    end
                end
                default: ;
            endcase
            // A malformed LF already ends the line, so it must not wait in SKIP
            // for another LF that belongs to the next command.
            if (bad) begin
                if (bus.rx_data == CH_LF) begin
                    state_next = S_RESP;
                    resp_next  = R_ERR;
                    idx_next   = '0;
                end else begin
                    state_next = S_SKIP;
                end
            end
        end

        if (state_reg == S_REQ) begin
            if (bus.reg_ack) begin
                req_next   = 1'b0;
                state_next = S_RESP;
                idx_next   = '0;
                resp_next  = is_write_reg ? R_OK : R_RD;
                if (!is_write_reg) rdata_next = bus.reg_rdata;
            end else if (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1)) begin
                req_next   = 1'b0;
                state_next = S_RESP;
                idx_next   = '0;
                resp_next  = R_TO;
            end else begin
                to_cnt_next = to_cnt_reg + 1'b1;
            end
        end

        if (state_reg == S_RESP && bus.tx_ready) begin
            if (idx_reg == resp_last) state_next = S_IDLE;
            else                      idx_next   = idx_reg + 1'b1;
        end

        rx_ready_next = (state_next != S_REQ) && (state_next != S_RESP);
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_hex
        logic [3:0] nib;
        assign nib         = rdata_reg[31-4*gi -: 4];
        assign hex_msb[gi] = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end

    assign idx_off = idx_reg - 4'd3;

    always_comb begin
        tx_char   = CH_LF;
        resp_last = 4'd2;
        case (resp_reg)
            R_OK: begin
                if (idx_reg == 4'd0)      tx_char = 8'h4F;
                else if (idx_reg == 4'd1) tx_char = 8'h4B;
            end
            R_TO: begin
                if (idx_reg == 4'd0)      tx_char = 8'h54;
                else if (idx_reg == 4'd1) tx_char = 8'h4F;
            end
            R_ERR: begin
                resp_last = 4'd3;
                if (idx_reg == 4'd0)                         tx_char = 8'h45;
                else if (idx_reg == 4'd1 || idx_reg == 4'd2) tx_char = 8'h52;
            end
            R_RD: begin
                resp_last = 4'd11;
                if (idx_reg == 4'd0)       tx_char = 8'h52;
                else if (idx_reg == 4'd1)  tx_char = 8'h44;
                else if (idx_reg == 4'd2)  tx_char = 8'h3A;
                else if (idx_reg != 4'd11) tx_char = hex_msb[idx_off[2:0]];
            end
            default: ;
        endcase
    end

    assign bus.rx_ready  = rx_ready_reg;
    assign bus.tx_valid  = (state_reg == S_RESP);
    assign bus.tx_data   = (state_reg == S_RESP) ? tx_char : 8'h00;
    assign bus.reg_req   = req_reg;
    assign bus.reg_we    = is_write_reg;
    assign bus.reg_addr  = addr_reg;
    assign bus.reg_wdata = wdata_reg;
    assign bus.reg_be    = 4'hF;
    assign bus.busy      = (state_reg != S_IDLE);
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench: table of command lines with expected request fields and
// response strings, plus hand sequences for timeout, stray ack and reset.
module tb_uart_cmd_parser;
    localparam int TO_CYC = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_parser_if bus();

    uart_cmd_parser #(.TIMEOUT_CYC(TO_CYC), .MAX_HEX(8)) dut (
        .app_clk (clk),
        .app_rst (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       line;
        bit          exp_req;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;   // 0 = never acknowledge
        logic [3:0]  rpat;     // tx_ready per TX-valid cycle, LSB first
        string       resp;
    } vec_t;

    function automatic vec_t mk(input string line, input bit exp_req, input bit we,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int ack_at,
                                input logic [3:0] rpat, input string resp);
        vec_t v;
        v.line = line; v.exp_req = exp_req; v.we = we; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.ack_at = ack_at; v.rpat = rpat;
        v.resp = resp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_wait: byte %h never accepted", b);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic service(input vec_t v, input string tag);
        string       got = "";
        int          req_cyc = 0;
        int          polls = 0;
        int          tx_cyc = 0;
        bit          saw_req = 0;
        bit          acked = 0;
        bit          done = 0;
        bit          held = 0;
        bit          rdy;
        logic [7:0]  held_data = 8'h00;
        while (!done && polls < TO_CYC + 200) begin
            bus.reg_ack = 1'b0;
            if (acked) begin
                check({tag, " req_drop"}, {31'd0, bus.reg_req}, 32'd0);
                check({tag, " resp_lat"}, {31'd0, bus.tx_valid}, 32'd1);
                acked = 0;
            end
            if (bus.reg_req) begin
                if (!saw_req) begin
                    saw_req = 1;
                    check({tag, " req_lat"}, polls, 0);
                    check({tag, " addr"}, bus.reg_addr, v.addr);
                    check({tag, " we"}, {31'd0, bus.reg_we}, {31'd0, v.we});
                    check({tag, " be"}, {28'd0, bus.reg_be}, 32'hF);
                    if (v.we) check({tag, " wdata"}, bus.reg_wdata, v.wdata);
                end else begin
                    check({tag, " addr_hold"}, bus.reg_addr, v.addr);
                end
                req_cyc++;
                if (req_cyc == v.ack_at) begin
                    bus.reg_ack   = 1'b1;
                    bus.reg_rdata = v.rdata;
                    acked = 1;
                end
            end
            if (held) check({tag, " tx_hold_valid"}, {31'd0, bus.tx_valid}, 32'd1);
            if (bus.tx_valid) begin
                if (held) check({tag, " tx_hold_data"}, {24'd0, bus.tx_data}, {24'd0, held_data});
                rdy = v.rpat[tx_cyc % 4];
                tx_cyc++;
                bus.tx_ready = rdy;
                if (rdy) begin
                    got  = $sformatf("%s%c", got, bus.tx_data);
                    held = 0;
                    if (bus.tx_data == 8'h0A) done = 1;
                end else begin
                    held      = 1;
                    held_data = bus.tx_data;
                end
            end else begin
                bus.tx_ready = 1'b0;
            end
            polls++;
            @(negedge clk);
        end
        bus.tx_ready = 1'b0;
        bus.reg_ack  = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s done: response never completed", tag);
        end
        check({tag, " req_seen"}, {31'd0, saw_req}, {31'd0, v.exp_req});
        if (v.exp_req && (v.ack_at == 0 || v.ack_at == TO_CYC))
            check({tag, " req_cycles"}, req_cyc, TO_CYC);
        check_str({tag, " resp"}, got, v.resp);
        check({tag, " busy_end"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " rx_ready_end"}, {31'd0, bus.rx_ready}, 32'd1);
        $display("txn %s line=%0d bytes req=%0d resp_len=%0d", tag, v.line.len(), saw_req, got.len());
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        send_line(v.line);
        service(v, tag);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (bus.reg_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " wait_req"}, {31'd0, bus.reg_req}, 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.tx_ready  = 1'b0;
        bus.reg_ack   = 1'b0;
        bus.reg_rdata = 32'h0;

        vecs.push_back(mk("wm 30020058 11223344\n", 1, 1, 32'h30020058, 32'h11223344, 32'h0, 3, 4'b1111, "OK\n"));
        vecs.push_back(mk("rm 3002005C\r\n", 1, 0, 32'h3002005C, 32'h0, 32'h22334455, 2, 4'b1001, "RD:22334455\n"));
        vecs.push_back(mk("rm 1f\n", 1, 0, 32'h0000001F, 32'h0, 32'hDEADBEEF, 1, 4'b1111, "RD:DEADBEEF\n"));
        vecs.push_back(mk("xm 10\n", 0, 0, 32'h0, 32'h0, 32'h0, 1, 4'b1111, "ERR\n"));
        vecs.push_back(mk("rm 123456789\n", 0, 0, 32'h0, 32'h0, 32'h0, 1, 4'b1111, "ERR\n"));
        vecs.push_back(mk("wm 10\n", 0, 0, 32'h0, 32'h0, 32'h0, 1, 4'b1111, "ERR\n"));
        vecs.push_back(mk("rm 10\n", 1, 0, 32'h00000010, 32'h0, 32'h0000ABCD, 4, 4'b1111, "RD:0000ABCD\n"));
        vecs.push_back(mk("  wm A 0\n", 1, 1, 32'h0000000A, 32'h0, 32'h0, 1, 4'b0101, "OK\n"));
        vecs.push_back(mk("rm  10\n", 0, 0, 32'h0, 32'h0, 32'h0, 1, 4'b1111, "ERR\n"));
        vecs.push_back(mk("wm 1 abcdefAB\n", 1, 1, 32'h00000001, 32'hABCDEFAB, 32'h0, 2, 4'b1111, "OK\n"));
        vecs.push_back(mk("rm 40\n", 1, 0, 32'h00000040, 32'h0, 32'h0, 0, 4'b1111, "TO\n"));
        vecs.push_back(mk("rm 40\n", 1, 0, 32'h00000040, 32'h0, 32'h01234567, TO_CYC, 4'b1111, "RD:01234567\n"));

        // Reset state
        repeat (3) @(negedge clk);
        check("rst rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        check("rst tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("rst reg_req", {31'd0, bus.reg_req}, 32'd0);
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst reg_be", {28'd0, bus.reg_be}, 32'hF);
        check("rst reg_addr", bus.reg_addr, 32'h0);
        check("rst reg_we", {31'd0, bus.reg_we}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Stray ack while idle must not start anything
        bus.reg_ack = 1'b1;
        bus.reg_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus.reg_ack = 1'b0;
        @(negedge clk);
        check("stray_ack tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("stray_ack busy", {31'd0, bus.busy}, 32'd0);
        $display("txn stray_ack idle");

        // Reset during RESP
        send_line("rm 10\n");
        wait_req("rst_resp");
        bus.reg_ack = 1'b1;
        bus.reg_rdata = 32'h12345678;
        @(negedge clk);
        bus.reg_ack = 1'b0;
        check("rst_resp tx_valid_pre", {31'd0, bus.tx_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_resp tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("rst_resp reg_req", {31'd0, bus.reg_req}, 32'd0);
        check("rst_resp busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        $display("txn reset_in_resp");

        // Reset during REQ
        send_line("wm 5 6\n");
        wait_req("rst_req");
        rst = 1'b1;
        @(negedge clk);
        check("rst_req reg_req", {31'd0, bus.reg_req}, 32'd0);
        check("rst_req busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        $display("txn reset_in_req");

        run_vec(vecs[6], "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
